mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset; asserted when 0, sampled on clk.
REQ-003 rdy  input  1  global run enable; 0 = freeze.
REQ-004 if_request  input  1  fetch read request, level, held until if_enable.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 jump_or_not  input  1  pipeline flush; cancels fetch service.
REQ-007 if_inst_o  output  32  assembled instruction word.
REQ-008 if_enable  output  1  one-cycle pulse: if_inst_o valid, fetch done.
REQ-009 mem_request  input  1  load/store request, level, held until mem_enable.
REQ-010 mem_wr_i  input  1  1 = store, 0 = load.
REQ-011 mem_addr_i  input  32  load/store byte address.
REQ-012 mem_len  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-013 mem_wdata  input  32  store data, little-endian, low bytes used.
REQ-014 mem_rdata_o  output  32  load data, zero-extended.
REQ-015 mem_enable  output  1  one-cycle pulse: load/store done.
REQ-016 ram_din  input  8  RAM read byte; valid one cycle after its address.
REQ-017 ram_dout  output  8  RAM write byte.
REQ-018 ram_a  output  32  RAM byte address.
REQ-019 ram_wr  output  1  1 = write ram_dout to ram_a this cycle.

Function
REQ-020 The block SHALL implement FSM states IDLE, IF_RD, MEM_RD, MEM_WR with byte counter cnt (0..4).
REQ-021 In IDLE, at a clk edge with rdy=1, the block SHALL grant mem_request over if_request; an if_request is not granted when jump_or_not=1 that cycle.
REQ-022 Cycle 0 = first cycle after grant; reads SHALL drive ram_a = addr+i, ram_wr=0 in cycle i, i = 0..N-1 (N = 1/2/4 bytes; fetch N=4).
REQ-023 Reads SHALL capture ram_din in cycle i+1 into byte lane i and pulse the enable in cycle N+1 with the full word stable on the data output.
REQ-024 Writes SHALL drive ram_a = addr+i, ram_dout = mem_wdata[8i+7:8i], ram_wr=1 in cycle i, and pulse mem_enable in cycle N.
REQ-025 The block SHALL return to IDLE in the enable cycle and arbitrate again from the next cycle; requesters drop request in the enable cycle.
REQ-026 In IDLE, ram_wr SHALL be 0 and ram_a SHALL be 0.
REQ-027 Unused upper bytes of mem_rdata_o SHALL be 0; data outputs SHALL hold until the next completion of the same port.
REQ-028 rdy=0 SHALL hold all registers, force ram_wr=0, and on resume re-present the address of the oldest uncaptured byte.
REQ-029 jump_or_not SHALL never affect a MEM_RD/MEM_WR transaction.
REQ-030 Enable pulses SHALL never coincide on both ports.

Reset
REQ-031 rst=0 at a clk edge SHALL force IDLE, cnt=0, if_enable=0, mem_enable=0, ram_wr=0, ram_a=0, ram_dout=0, if_inst_o=0, mem_rdata_o=0, aborting any transaction, with priority over rdy.

Configuration
REQ-032 With IF_ABORT_EN defined, jump_or_not=1 during IF_RD SHALL return to IDLE at the next edge with no if_enable pulse.
REQ-033 Without IF_ABORT_EN, a jump during IF_RD SHALL let the read complete on schedule but suppress its if_enable pulse and leave if_inst_o unchanged.

Verification
REQ-034 Fetch addr 0x100, RAM bytes 13 05 00 00 -> ram_a 0x100..0x103 cycles 0-3, if_enable in cycle 5, if_inst_o=0x00000513.
REQ-035 mem_request and if_request raised same edge, store half 0xBEEF to 0x200 -> ram_wr cycles 0-1 writing EF, BE; mem_enable cycle 2; fetch starts cycle 3.
REQ-036 Byte load from 0x1003 holding 0x80 -> mem_rdata_o=0x00000080, mem_enable in cycle 2.
REQ-037 jump_or_not pulsed in cycle 2 of a fetch -> IF_ABORT_EN: IDLE next cycle, no if_enable; otherwise no if_enable, if_inst_o unchanged.
REQ-038 rdy low in cycles 1-3 of a word load, then rst=0 mid-store -> correct word delayed 3 cycles; after reset all outputs 0, ram_wr 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM between an instruction-fetch port and a
// load/store port. Words are moved one byte per cycle, little-endian.
//
// Ports
//   clk, rst (sync, active-low), rdy (global run enable, 0 = freeze)
//   Fetch port : if_request, if_addr, jump_or_not -> if_inst_o, if_enable
//   Data port  : mem_request, mem_wr_i, mem_addr_i, mem_len, mem_wdata
//                -> mem_rdata_o, mem_enable
//   RAM side   : ram_din (one-cycle read latency) -> ram_dout, ram_a, ram_wr
//
// Build option
//   IF_ABORT_EN : a jump during a fetch drops the fetch at the next edge.
//                 Without it the fetch runs to completion and its result is
//                 discarded (no if_enable, if_inst_o untouched).
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_request,
    input  logic [31:0] if_addr,
    input  logic        jump_or_not,
    output logic [31:0] if_inst_o,
    output logic        if_enable,
    input  logic        mem_request,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata_o,
    output logic        mem_enable,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  nbytes_q;
    logic [31:0] ram_a_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] if_inst_q;
    logic [31:0] mem_rdata_q;
    logic [7:0]  ram_dout_q;
    logic        ram_wr_q;
    logic        if_en_q;
    logic        mem_en_q;
    logic        kill_q;
    logic [31:0] rd_word_d;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // In read states cnt_q = c means ram_din holds byte c-1 (address sent last cycle).
    always_comb begin
        rd_word_d = buf_q;
        case (cnt_q)
            3'd1:    rd_word_d[7:0]   = ram_din;
            3'd2:    rd_word_d[15:8]  = ram_din;
            3'd3:    rd_word_d[23:16] = ram_din;
            3'd4:    rd_word_d[31:24] = ram_din;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            if_en_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_a_q     <= 32'd0;
            ram_dout_q  <= 8'd0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            kill_q      <= 1'b0;
        end else if (rdy) begin
            if_en_q  <= 1'b0;
            mem_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q  <= 3'd0;
                    buf_q  <= 32'd0;
                    kill_q <= 1'b0;
                    // Data port wins; a flushed fetch request is not accepted.
                    if (mem_request) begin
                        state_q    <= mem_wr_i ? MEM_WR : MEM_RD;
                        nbytes_q   <= len_bytes(mem_len);
                        ram_a_q    <= mem_addr_i;
                        wdata_q    <= mem_wdata;
                        ram_wr_q   <= mem_wr_i;
                        ram_dout_q <= mem_wr_i ? mem_wdata[7:0] : 8'd0;
                    end else if (if_request && !jump_or_not) begin
                        state_q    <= IF_RD;
                        nbytes_q   <= 3'd4;
                        ram_a_q    <= if_addr;
                        ram_wr_q   <= 1'b0;
                        ram_dout_q <= 8'd0;
                    end
                end
                IF_RD, MEM_RD: begin
                    buf_q <= rd_word_d;
                    if (cnt_q == nbytes_q) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                        ram_a_q <= 32'd0;
                        if (state_q == MEM_RD) begin
                            mem_rdata_q <= rd_word_d;
                            mem_en_q    <= 1'b1;
                        end else if (!(kill_q || jump_or_not)) begin
                            if_inst_q <= rd_word_d;
                            if_en_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_q + 3'd1;
                        ram_a_q <= ram_a_q + 32'd1;
                    end
`ifdef IF_ABORT_EN
                    if (state_q == IF_RD && jump_or_not) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                        ram_a_q <= 32'd0;
                        if_en_q <= 1'b0;
                    end
`else
                    if (state_q == IF_RD && jump_or_not) begin
                        kill_q <= 1'b1;
                    end
`endif
                end
                MEM_WR: begin
                    if (cnt_q + 3'd1 == nbytes_q) begin
                        state_q    <= IDLE;
                        cnt_q      <= 3'd0;
                        ram_a_q    <= 32'd0;
                        ram_wr_q   <= 1'b0;
                        ram_dout_q <= 8'd0;
                        mem_en_q   <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q + 3'd1;
                        ram_a_q    <= ram_a_q + 32'd1;
                        ram_dout_q <= lane(wdata_q, 2'(cnt_q + 3'd1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // While frozen the RAM keeps reading, so a read presents the byte it still
    // owes (ram_a_q - 1); the byte then lands on ram_din in the first run cycle.
    always_comb begin
        ram_a = ram_a_q;
        if (!rdy && (state_q == IF_RD || state_q == MEM_RD) && cnt_q != 3'd0) begin
            ram_a = ram_a_q - 32'd1;
        end
    end

    assign ram_wr      = ram_wr_q & rdy;
    assign ram_dout    = ram_dout_q;
    assign if_enable   = if_en_q & rdy;
    assign mem_enable  = mem_en_q & rdy;
    assign if_inst_o   = if_inst_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule
